imm_extend_stage: RTL and testbench

Pipelined immediate generator for the LEGv8 datapath. It classifies each fetched instruction word by format (B, CB, D, I, IW), extracts the immediate field and sign- or zero-extends it to a parametrised datapath width. Results pass through a registered valid/ready stage with a skid entry, so full throughput is kept under backpressure. It sits between fetch/decode and the register-read stage and replaces the single-cycle combinational extender.

---
 rtl/imm_pkg.sv | 57 +++++
 rtl/imm_decode.sv | 85 ++++++++
 rtl/imm_extend_stage.sv | 113 +++++++++++
 tb/tb_imm_extend_stage.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// ============================================================================
// Module      : imm_pkg
// Description : LEGv8 immediate formats, opcode match/mask pairs and field
//               positions shared by the immediate extend stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_B    = 3'd1,
      FMT_CB   = 3'd2,
      FMT_D    = 3'd3,
      FMT_I    = 3'd4,
      FMT_IW   = 3'd5
   } imm_fmt_t;

   // Opcode classification: (instr & mask) == match
   localparam logic [31:0] c_b_mask    = 32'h7C00_0000;  // [30:26]
   localparam logic [31:0] c_b_match   = 32'h1400_0000;  // 00101
   localparam logic [31:0] c_cbz_mask  = 32'h7E00_0000;  // [30:25]
   localparam logic [31:0] c_cbz_match = 32'h3400_0000;  // 011010
   localparam logic [31:0] c_bc_mask   = 32'hFF00_0000;  // [31:24]
   localparam logic [31:0] c_bc_match  = 32'h5400_0000;  // 01010100
   localparam logic [31:0] c_iw_mask   = 32'h1F80_0000;  // [28:23]
   localparam logic [31:0] c_iw_match  = 32'h1280_0000;  // 100101
   localparam logic [31:0] c_ia_mask   = 32'h1F00_0000;  // [28:24]
   localparam logic [31:0] c_ia_match  = 32'h1100_0000;  // 10001
   localparam logic [31:0] c_il_mask   = 32'h1F80_0000;  // [28:23]
   localparam logic [31:0] c_il_match  = 32'h1200_0000;  // 100100
   localparam logic [31:0] c_d_mask    = 32'h3900_0000;  // [29:27],[24]
   localparam logic [31:0] c_d_match   = 32'h3800_0000;  // 111,0

   localparam int c_imm26_msb = 25;
   localparam int c_imm26_lsb = 0;
   localparam int c_imm19_msb = 23;
   localparam int c_imm19_lsb = 5;
   localparam int c_imm16_msb = 20;
   localparam int c_imm16_lsb = 5;
   localparam int c_hw_msb    = 22;
   localparam int c_hw_lsb    = 21;
   localparam int c_imm12_msb = 21;
   localparam int c_imm12_lsb = 10;
   localparam int c_imm9_msb  = 20;
   localparam int c_imm9_lsb  = 12;

   function automatic logic op_match(input logic [31:0] instr,
                                     input logic [31:0] mask,
                                     input logic [31:0] match);
      return (instr & mask) == match;
   endfunction

endpackage

`default_nettype wire

// File: rtl/imm_decode.sv
// ============================================================================
// Module      : imm_decode
// Description : Combinational LEGv8 format classifier and immediate extender.
//               Macro IMM_BRANCH_SHIFT_EN turns B/CB word offsets into bytes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imm_decode
   import imm_pkg::*;
#(
   parameter int DATA_W = 64
) (
   input  logic [31:0]       instr,
   output imm_fmt_t          fmt,
   output logic [DATA_W-1:0] imm,
   output logic              illegal
);

   localparam logic [6:0] c_data_w = 7'(DATA_W);

   logic [25:0]       w_imm26;
   logic [18:0]       w_imm19;
   logic [15:0]       w_imm16;
   logic [1:0]        w_hw;
   logic [11:0]       w_imm12;
   logic [8:0]        w_imm9;
   logic [DATA_W-1:0] w_b_ext;
   logic [DATA_W-1:0] w_cb_ext;
   logic [DATA_W-1:0] w_d_ext;
   logic [DATA_W-1:0] w_i_ext;
   logic [DATA_W-1:0] w_iw_ext;
   logic [6:0]        w_iw_top;
   logic              w_iw_ill;

   assign w_imm26 = instr[c_imm26_msb:c_imm26_lsb];
   assign w_imm19 = instr[c_imm19_msb:c_imm19_lsb];
   assign w_imm16 = instr[c_imm16_msb:c_imm16_lsb];
   assign w_hw    = instr[c_hw_msb:c_hw_lsb];
   assign w_imm12 = instr[c_imm12_msb:c_imm12_lsb];
   assign w_imm9  = instr[c_imm9_msb:c_imm9_lsb];

`ifdef IMM_BRANCH_SHIFT_EN
   assign w_b_ext  = {{(DATA_W-28){w_imm26[25]}}, w_imm26, 2'b00};
   assign w_cb_ext = {{(DATA_W-21){w_imm19[18]}}, w_imm19, 2'b00};
`else
   assign w_b_ext  = {{(DATA_W-26){w_imm26[25]}}, w_imm26};
   assign w_cb_ext = {{(DATA_W-19){w_imm19[18]}}, w_imm19};
`endif

   assign w_d_ext  = {{(DATA_W-9){w_imm9[8]}}, w_imm9};
   assign w_i_ext  = {{(DATA_W-12){1'b0}}, w_imm12};
   // Shifting inside DATA_W bits performs the required truncation
   assign w_iw_ext = {{(DATA_W-16){1'b0}}, w_imm16} << {w_hw, 4'b0000};
   assign w_iw_top = {1'b0, w_hw, 4'b0000} + 7'd16;
   assign w_iw_ill = w_iw_top > c_data_w;

   always_comb begin
      fmt     = FMT_NONE;
      imm     = '0;
      illegal = 1'b0;
      if (op_match(instr, c_b_mask, c_b_match)) begin
         fmt = FMT_B;
         imm = w_b_ext;
      end else if (op_match(instr, c_cbz_mask, c_cbz_match) ||
                   op_match(instr, c_bc_mask, c_bc_match)) begin
         fmt = FMT_CB;
         imm = w_cb_ext;
      end else if (op_match(instr, c_iw_mask, c_iw_match)) begin
         fmt     = FMT_IW;
         illegal = w_iw_ill;
         imm     = w_iw_ill ? '0 : w_iw_ext;
      end else if (op_match(instr, c_ia_mask, c_ia_match) ||
                   op_match(instr, c_il_mask, c_il_match)) begin
         fmt = FMT_I;
         imm = w_i_ext;
      end else if (op_match(instr, c_d_mask, c_d_match)) begin
         fmt = FMT_D;
         imm = w_d_ext;
      end
   end

endmodule

`default_nettype wire

// File: rtl/imm_extend_stage.sv
// ============================================================================
// Module      : imm_extend_stage
// Description : Registered valid/ready immediate stage with a skid entry.
//               Optional macro IMM_BRANCH_SHIFT_EN (see imm_decode).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module imm_extend_stage
   import imm_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int TAG_W  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_imm,
   output imm_fmt_t          out_fmt,
   output logic              out_illegal,
   output logic [TAG_W-1:0]  out_tag
);

   imm_fmt_t          w_dec_fmt;
   logic [DATA_W-1:0] w_dec_imm;
   logic              w_dec_ill;

   imm_decode #(.DATA_W(DATA_W)) u_decode (
      .instr   (in_instr),
      .fmt     (w_dec_fmt),
      .imm     (w_dec_imm),
      .illegal (w_dec_ill)
   );

   logic              r_main_valid, r_skid_valid, r_in_ready;
   logic [DATA_W-1:0] r_main_imm, r_skid_imm;
   imm_fmt_t          r_main_fmt, r_skid_fmt;
   logic              r_main_ill, r_skid_ill;
   logic [TAG_W-1:0]  r_main_tag, r_skid_tag;

   logic w_in_fire, w_out_fire;
   logic w_main_from_in, w_main_from_skid, w_skid_load;
   logic w_main_valid_nx, w_skid_valid_nx;

   // An input transfer implies the skid entry is empty
   assign w_in_fire        = in_valid & r_in_ready;
   assign w_out_fire       = r_main_valid & out_ready;
   assign w_main_from_skid = w_out_fire & r_skid_valid;
   assign w_main_from_in   = w_in_fire & (~r_main_valid | w_out_fire);
   assign w_skid_load      = w_in_fire & r_main_valid & ~w_out_fire;
   assign w_main_valid_nx  = w_main_from_in | w_main_from_skid | (r_main_valid & ~w_out_fire);
   assign w_skid_valid_nx  = w_skid_load | (r_skid_valid & ~w_main_from_skid);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
      end else begin
         r_main_valid <= w_main_valid_nx;
         r_skid_valid <= w_skid_valid_nx;
         r_in_ready   <= ~w_skid_valid_nx;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_main_imm <= '0;
         r_main_fmt <= FMT_NONE;
         r_main_ill <= 1'b0;
         r_main_tag <= '0;
      end else if (w_main_from_skid) begin
         r_main_imm <= r_skid_imm;
         r_main_fmt <= r_skid_fmt;
         r_main_ill <= r_skid_ill;
         r_main_tag <= r_skid_tag;
      end else if (w_main_from_in) begin
         r_main_imm <= w_dec_imm;
         r_main_fmt <= w_dec_fmt;
         r_main_ill <= w_dec_ill;
         r_main_tag <= in_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_skid_imm <= '0;
         r_skid_fmt <= FMT_NONE;
         r_skid_ill <= 1'b0;
         r_skid_tag <= '0;
      end else if (w_skid_load) begin
         r_skid_imm <= w_dec_imm;
         r_skid_fmt <= w_dec_fmt;
         r_skid_ill <= w_dec_ill;
         r_skid_tag <= in_tag;
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_main_valid;
   assign out_imm     = r_main_imm;
   assign out_fmt     = r_main_fmt;
   assign out_illegal = r_main_ill;
   assign out_tag     = r_main_tag;

endmodule

`default_nettype wire

// File: tb/tb_imm_extend_stage.sv
// ============================================================================
// Module      : tb_imm_extend_stage
// Description : Directed and randomised-handshake bench for imm_extend_stage.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_imm_extend_stage;

   typedef struct packed {
      logic [31:0] instr;
      logic [2:0]  fmt;
      logic [63:0] imm;
      logic        ill;
      logic        ill32;
   } vec_t;

   typedef struct packed {
      logic [31:0] idx;
      logic [63:0] tag;
   } exp_t;

   localparam int NV = 13;

`ifdef IMM_BRANCH_SHIFT_EN
   localparam logic [63:0] B_NEG  = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [63:0] B_POS  = 64'h40;
   localparam logic [63:0] CB_NEG = 64'hFFFF_FFFF_FFFF_FFFC;
   localparam logic [63:0] CB_POS = 64'h8;
`else
   localparam logic [63:0] B_NEG  = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] B_POS  = 64'h10;
   localparam logic [63:0] CB_NEG = 64'hFFFF_FFFF_FFFF_FFFF;
   localparam logic [63:0] CB_POS = 64'h2;
`endif

   function automatic vec_t vec(input int i);
      case (i)
         0:  vec = '{32'h17FF_FFFF, 3'd1, B_NEG, 1'b0, 1'b0};
         1:  vec = '{32'h1400_0010, 3'd1, B_POS, 1'b0, 1'b0};
         2:  vec = '{32'hB4FF_FFE0, 3'd2, CB_NEG, 1'b0, 1'b0};
         3:  vec = '{32'h5400_0041, 3'd2, CB_POS, 1'b0, 1'b0};
         4:  vec = '{32'hF85F_8020, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0};
         5:  vec = '{32'hF801_0020, 3'd3, 64'h10, 1'b0, 1'b0};
         6:  vec = '{32'h91FF_FC00, 3'd4, 64'hFFF, 1'b0, 1'b0};
         7:  vec = '{32'h9240_0C00, 3'd4, 64'h3, 1'b0, 1'b0};
         8:  vec = '{32'hD2A0_0020, 3'd5, 64'h1_0000, 1'b0, 1'b0};
         9:  vec = '{32'hD2C0_0020, 3'd5, 64'h1_0000_0000, 1'b0, 1'b1};
         10: vec = '{32'hD2E0_0020, 3'd5, 64'h0001_0000_0000_0000, 1'b0, 1'b1};
         11: vec = '{32'h8B02_0020, 3'd0, 64'h0, 1'b0, 1'b0};
         default: vec = '{32'hF940_0020, 3'd0, 64'h0, 1'b0, 1'b0};
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [63:0] in_tag;
   logic        out_ready;
   logic        in_ready, out_valid, out_illegal;
   logic [63:0] out_imm, out_tag;
   logic [2:0]  out_fmt;
   logic        in_ready32, out_valid32, out_ill32;
   logic [31:0] out_imm32;
   logic [2:0]  out_fmt32;
   logic [63:0] out_tag32;

   always #5 clk = ~clk;

   imm_extend_stage #(.DATA_W(64), .TAG_W(64)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
      .out_illegal(out_illegal), .out_tag(out_tag)
   );

   imm_extend_stage #(.DATA_W(32), .TAG_W(64)) dut32 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
      .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32),
      .out_ready(1'b1), .out_imm(out_imm32), .out_fmt(out_fmt32),
      .out_illegal(out_ill32), .out_tag(out_tag32)
   );

   int          checks   = 0;
   int          failures = 0;
   int          cur_idx  = 0;
   logic        accepted = 1'b0;
   logic        hold_v   = 1'b0;
   logic [63:0] hold_imm, hold_tag;
   logic [2:0]  hold_fmt;
   exp_t        q[$];

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic drive(input int idx, input logic [63:0] tag);
      vec_t v;
      v        = vec(idx);
      in_valid = 1'b1;
      in_instr = v.instr;
      in_tag   = tag;
      cur_idx  = idx;
   endtask

   // One clock: observe transfers at negedge, return at posedge+1
   task automatic tick();
      exp_t e;
      vec_t v;
      @(negedge clk);
      if (hold_v) begin
         chk("hold_valid", {63'd0, out_valid}, 64'd1);
         chk("hold_imm", out_imm, hold_imm);
         chk("hold_fmt", {61'd0, out_fmt}, {61'd0, hold_fmt});
         chk("hold_tag", out_tag, hold_tag);
      end
      hold_v   = out_valid && !out_ready;
      hold_imm = out_imm;
      hold_fmt = out_fmt;
      hold_tag = out_tag;
      if (out_valid && out_ready) begin
         chk("stream_pending", 64'(q.size() != 0), 64'd1);
         if (q.size() != 0) begin
            e = q.pop_front();
            v = vec(int'(e.idx));
            chk("stream_tag", out_tag, e.tag);
            chk("stream_fmt", {61'd0, out_fmt}, {61'd0, v.fmt});
            chk("stream_imm", out_imm, v.imm);
            chk("stream_ill", {63'd0, out_illegal}, {63'd0, v.ill});
         end
      end
      accepted = in_valid && in_ready;
      if (accepted) q.push_back('{32'(cur_idx), in_tag});
      @(posedge clk);
      #1;
   endtask

   initial begin
      vec_t v;
      int   sent;
      int   cyc;
      logic done;
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_tag = '0; out_ready = 1'b1;
      #12;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
      chk("rst_out_imm", out_imm, 64'd0);
      chk("rst_out_fmt", {61'd0, out_fmt}, 64'd0);
      chk("rst_out_ill", {63'd0, out_illegal}, 64'd0);
      chk("rst_out_tag", out_tag, 64'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed vectors, back to back, both widths
      for (int i = 0; i < NV; i++) begin
         v = vec(i);
         drive(i, 64'h1000 + 64'(i));
         tick();
         chk("dir_valid", {63'd0, out_valid}, 64'd1);
         chk("dir_fmt", {61'd0, out_fmt}, {61'd0, v.fmt});
         chk("dir_imm", out_imm, v.imm);
         chk("dir_ill", {63'd0, out_illegal}, {63'd0, v.ill});
         chk("dir_tag", out_tag, 64'h1000 + 64'(i));
         chk("dir32_imm", {32'd0, out_imm32}, {32'd0, v.imm[31:0]});
         chk("dir32_ill", {63'd0, out_ill32}, {63'd0, v.ill32});
      end
      in_valid = 1'b0;
      tick();
      chk("dir_drained", {63'd0, out_valid}, 64'd0);

      // Backpressure: three stalled cycles, then release
      out_ready = 1'b0;
      drive(4, 64'h201); tick();
      chk("bp_w1_tag", out_tag, 64'h201);
      chk("bp_ready_w1", {63'd0, in_ready}, 64'd1);
      drive(5, 64'h202); tick();
      chk("bp_ready_drop", {63'd0, in_ready}, 64'd0);
      chk("bp_w1_hold", out_tag, 64'h201);
      drive(6, 64'h203); tick();
      chk("bp_ready_low", {63'd0, in_ready}, 64'd0);
      chk("bp_w1_hold2", out_imm, 64'hFFFF_FFFF_FFFF_FFF8);
      out_ready = 1'b1;
      #1;
      chk("no_comb_ready", {63'd0, in_ready}, 64'd0);
      tick();
      chk("bp_w2_tag", out_tag, 64'h202);
      chk("bp_ready_rise", {63'd0, in_ready}, 64'd1);
      tick();
      chk("bp_w3_tag", out_tag, 64'h203);
      drive(7, 64'h204); tick();
      chk("bp_w4_tag", out_tag, 64'h204);
      in_valid = 1'b0;
      tick();
      chk("bp_drain_valid", {63'd0, out_valid}, 64'd0);
      chk("bp_drain_queue", 64'(q.size()), 64'd0);

      // Reset with both entries full
      out_ready = 1'b0;
      drive(0, 64'h301); tick();
      drive(1, 64'h302); tick();
      in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("mid_rst_ready", {63'd0, in_ready}, 64'd1);
      chk("mid_rst_tag", out_tag, 64'd0);
      q.delete();
      hold_v = 1'b0;
      #1;
      rst = 1'b0;
      out_ready = 1'b1;
      drive(2, 64'h303); tick();
      chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
      chk("post_rst_tag", out_tag, 64'h303);
      chk("post_rst_imm", out_imm, CB_NEG);
      in_valid = 1'b0;
      tick();
      chk("post_rst_queue", 64'(q.size()), 64'd0);

      // Random valid/ready traffic checked against the reference queue
      sent = 0; cyc = 0; done = 1'b0; accepted = 1'b0;
      while (!done && cyc < 60000) begin
         if (!in_valid || accepted) begin
            if (sent < 10000 && $urandom_range(0, 3) != 0) begin
               drive(int'($urandom_range(0, NV-1)), {$urandom, $urandom});
               sent++;
            end else begin
               in_valid = 1'b0;
            end
         end
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
         cyc++;
         done = (sent == 10000) && (!in_valid || accepted) && (q.size() == 0) && !out_valid;
      end
      chk("random_done", {63'd0, done}, 64'd1);
      chk("random_queue", 64'(q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
